// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM states shared by the sequential ALU and its iteration core
package alu_pkg;
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;
    localparam logic [4:0] OP_DIV = 5'd7;
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
endpackage

// File: rtl/alu_seq_multdiv_if.sv
// alu_seq_multdiv_if: start/busy/ready request and result bundle of the execute-stage ALU
interface alu_seq_multdiv_if #(parameter int WIDTH = 32);
    localparam int SHAMT_W = $clog2(WIDTH);
    logic               ctrl_start;
    logic [4:0]         ctrl_ALUopcode;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic [WIDTH-1:0]   data_operandA;
    logic [WIDTH-1:0]   data_operandB;
    logic [WIDTH-1:0]   data_result;
    logic               data_resultRDY;
    logic               busy;
    logic               isNotEqual;
    logic               isLessThan;
    logic               overflow;
    logic               data_exception;
    modport master (
        output ctrl_start, ctrl_ALUopcode, ctrl_shiftamt, data_operandA, data_operandB,
        input  data_result, data_resultRDY, busy, isNotEqual, isLessThan, overflow, data_exception
    );
    modport slave (
        input  ctrl_start, ctrl_ALUopcode, ctrl_shiftamt, data_operandA, data_operandB,
        output data_result, data_resultRDY, busy, isNotEqual, isLessThan, overflow, data_exception
    );
endinterface

// File: rtl/alu_iter_core.sv
// alu_iter_core: one shift-add (MUL) or restoring-division step (DIV) per cycle on unsigned magnitudes
module alu_iter_core #(parameter int WIDTH = 32) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] ma,
    input  logic [WIDTH-1:0] mb,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             last
);
    localparam int CNT_W = $clog2(WIDTH);
    logic [WIDTH-1:0] md, hi_n, lo_n;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   sum, sh, dif;
    logic             ok;
    // {hi,lo} is the product for MUL and {remainder,quotient} for DIV
    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, md} : '0);
        sh   = {hi, lo[WIDTH-1]};
        dif  = sh - {1'b0, md};
        ok   = !dif[WIDTH];
        hi_n = is_div ? (ok ? dif[WIDTH-1:0] : sh[WIDTH-1:0]) : sum[WIDTH:1];
        lo_n = is_div ? {lo[WIDTH-2:0], ok} : {sum[0], lo[WIDTH-1:1]};
    end
    assign last = cnt == '0;
    always_ff @(posedge clock) begin
        if (reset) begin
            hi  <= '0;
            lo  <= '0;
            md  <= '0;
            cnt <= '0;
        end else if (load) begin
            hi  <= '0;
            lo  <= ma;
            md  <= mb;
            cnt <= CNT_W'(WIDTH - 1);
        end else if (step) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/alu_seq_multdiv.sv
// alu_seq_multdiv: registered execute-stage ALU, single-cycle logic/add/shift ops plus iterative signed MUL/DIV
module alu_seq_multdiv import alu_pkg::*; #(parameter int WIDTH = 32) (
    input logic              clock,
    input logic              reset,
    alu_seq_multdiv_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    state_t state, state_nxt;
    logic [4:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, ma, mb, hi, lo, sum_ab, dif_ab, sra, s_res, f_res, q;
    logic [SHAMT_W-1:0] sh_q, sh_m;
    logic [2*WIDTH-1:0] pr;
    logic               v_q, neg_q, dz_q, accept, is_md, last, is_add, s_ovf, f_ovf;
    assign accept   = bus.ctrl_start && state == IDLE;
    assign is_md    = bus.ctrl_ALUopcode == OP_MUL || bus.ctrl_ALUopcode == OP_DIV;
    assign ma       = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign mb       = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
    assign bus.busy = state != IDLE;
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? ((accept && is_md) ? ITER : IDLE)
                  : state == ITER ? (last ? FIX : ITER) : IDLE;
    end
    alu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clock (clock),
        .reset (reset),
        .load  (accept && is_md),
        .step  (state == ITER),
        .is_div(op_q == OP_DIV),
        .ma    (ma),
        .mb    (mb),
        .hi    (hi),
        .lo    (lo),
        .last  (last)
    );
    // unlisted opcodes fall through to ADD, including its overflow rule
    always_comb begin
        sum_ab = a_q + b_q;
        dif_ab = a_q - b_q;
        sh_m   = SHAMT_W'(32'(sh_q) % WIDTH);
        sra    = $signed(a_q) >>> sh_m;
        is_add = !(op_q inside {OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRA});
        s_res  = op_q == OP_SUB ? dif_ab : op_q == OP_AND ? a_q & b_q : op_q == OP_OR ? a_q | b_q
               : op_q == OP_SLL ? a_q << sh_m : op_q == OP_SRA ? sra : sum_ab;
        s_ovf  = op_q == OP_SUB ? (a_q[WIDTH-1] != b_q[WIDTH-1] && dif_ab[WIDTH-1] != a_q[WIDTH-1])
               : is_add && (a_q[WIDTH-1] == b_q[WIDTH-1] && sum_ab[WIDTH-1] != a_q[WIDTH-1]);
        pr     = neg_q ? -{hi, lo} : {hi, lo};
        q      = neg_q ? -lo : lo;
        f_res  = dz_q ? '0 : op_q == OP_DIV ? q : pr[WIDTH-1:0];
        // only MIN/-1 yields a positive quotient magnitude of 2^(WIDTH-1)
        f_ovf  = op_q == OP_DIV ? (!dz_q && !neg_q && lo[WIDTH-1])
               : pr[2*WIDTH-1:WIDTH] != {WIDTH{pr[WIDTH-1]}};
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            v_q                <= 1'b0;
            op_q               <= '0;
            a_q                <= '0;
            b_q                <= '0;
            sh_q               <= '0;
            neg_q              <= 1'b0;
            dz_q               <= 1'b0;
            bus.data_result    <= '0;
            bus.data_resultRDY <= 1'b0;
            bus.isNotEqual     <= 1'b0;
            bus.isLessThan     <= 1'b0;
            bus.overflow       <= 1'b0;
            bus.data_exception <= 1'b0;
        end else begin
            state              <= state_nxt;
            v_q                <= accept && !is_md;
            bus.data_resultRDY <= v_q || state == FIX;
            if (accept) begin
                op_q  <= bus.ctrl_ALUopcode;
                a_q   <= bus.data_operandA;
                b_q   <= bus.data_operandB;
                sh_q  <= bus.ctrl_shiftamt;
                neg_q <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                dz_q  <= bus.ctrl_ALUopcode == OP_DIV && bus.data_operandB == '0;
            end
            if (v_q || state == FIX) begin
                bus.data_result    <= v_q ? s_res : f_res;
                bus.overflow       <= v_q ? s_ovf : f_ovf;
                bus.data_exception <= !v_q && dz_q;
                bus.isNotEqual     <= a_q != b_q;
                bus.isLessThan     <= $signed(a_q) < $signed(b_q);
            end
        end
    end
endmodule
